// File: rtl/gamepad_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// gamepad_sequencer_pkg
// Shared definitions for the gamepad sequencer: button and command bit
// positions, FSM state encoding, default timing constants and a small helper.
// -----------------------------------------------------------------------------
package gamepad_sequencer_pkg;

   // Bit positions within the 8-bit buttons vector (active-high pressed).
   // The pad shifts A out first, so serial bit n lands at buttons[7-n].
   localparam int BTN_A      = 7;
   localparam int BTN_B      = 6;
   localparam int BTN_SELECT = 5;
   localparam int BTN_START  = 4;
   localparam int BTN_UP     = 3;
   localparam int BTN_DOWN   = 2;
   localparam int BTN_LEFT   = 1;
   localparam int BTN_RIGHT  = 0;

   // Bit positions within the 7-bit cmd strobe vector.
   localparam int CMD_ROT_CW    = 6;
   localparam int CMD_ROT_CCW   = 5;
   localparam int CMD_PAUSE     = 4;
   localparam int CMD_HARD_DROP = 3;
   localparam int CMD_DOWN      = 2;
   localparam int CMD_LEFT      = 1;
   localparam int CMD_RIGHT     = 0;

   // Default timing (40 MHz clock, 60 Hz polling, 12 us latch, 6 us half-period).
   localparam int DEF_CLK_HZ    = 40_000_000;
   localparam int DEF_POLL_DIV  = 666_666;
   localparam int DEF_LATCH_CYC = 480;
   localparam int DEF_HALF_CYC  = 240;
   localparam int DEF_DAS_DELAY = 16;
   localparam int DEF_DAS_RATE  = 6;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LATCH = 3'd1,
      ST_LOW   = 3'd2,
      ST_HIGH  = 3'd3,
      ST_DONE  = 3'd4
   } state_e;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/gamepad_sequencer_autorepeat_unit.sv
// -----------------------------------------------------------------------------
// autorepeat_unit
// Delayed auto-shift for one direction: fires on the press frame, again
// DAS_DELAY frames later, then every DAS_RATE frames while the button is held.
//
// Ports
//   clk, reset  : clock, synchronous active-high reset
//   frame_tick  : high on the cycle a new frame of button state is available
//   held        : button state of the new frame
//   inhibit     : forces the unit idle (counter held at 0, no fire)
//   fire        : combinational, high with frame_tick when a command is due
// -----------------------------------------------------------------------------
module autorepeat_unit
   import gamepad_sequencer_pkg::*;
#(
   parameter int DAS_DELAY = DEF_DAS_DELAY,
   parameter int DAS_RATE  = DEF_DAS_RATE
) (
   input  logic clk,
   input  logic reset,
   input  logic frame_tick,
   input  logic held,
   input  logic inhibit,
   output logic fire
);

   localparam int CNT_W = $clog2(max2(DAS_DELAY, DAS_RATE) + 1);

   // cnt_q counts frames since the last fire; 0 means "not held last frame".
   // armed_q selects the repeat period once the initial delay has elapsed.
   logic [CNT_W-1:0] cnt_q, cnt_d, target;
   logic             armed_q, armed_d;
   logic             active, due;

   always_comb begin
      active  = held & ~inhibit;
      target  = armed_q ? CNT_W'(DAS_RATE) : CNT_W'(DAS_DELAY);
      due     = (cnt_q == '0) || (cnt_q == target);
      fire    = frame_tick & active & due;
      cnt_d   = cnt_q;
      armed_d = armed_q;
      if (frame_tick) begin
         if (!active) begin
            cnt_d   = '0;
            armed_d = 1'b0;
         end else if (due) begin
            cnt_d   = CNT_W'(1);
            armed_d = armed_q | (cnt_q != '0);
         end else if (cnt_q != '1) begin
            cnt_d   = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q   <= '0;
         armed_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         armed_q <= armed_d;
      end
   end

endmodule

// File: rtl/gamepad_sequencer.sv
// -----------------------------------------------------------------------------
// gamepad_sequencer
// Polls a serial game pad (latch / shift-clock / active-low data), assembles
// the 8 button bits, and turns them into one-cycle game command strobes with
// press detection and auto-repeat for the movement directions.
//
// Ports
//   clk          : system clock
//   reset        : synchronous active-high reset
//   enable       : allows new scans to start (a running scan always finishes)
//   button_data  : pad serial data, active-low, already synchronised
//   latch, pulse : registered pad strobes
//   buttons      : pressed state, bit7..0 = A,B,Select,Start,Up,Down,Left,Right
//   frame_valid  : one-cycle strobe when buttons updates
//   cmd          : one-cycle strobes, bit6..0 = rot_cw,rot_ccw,pause,
//                  hard_drop,down,left,right; zero whenever frame_valid is low
// -----------------------------------------------------------------------------
module gamepad_sequencer
   import gamepad_sequencer_pkg::*;
#(
   parameter int CLK_HZ    = DEF_CLK_HZ,
   parameter int POLL_DIV  = DEF_POLL_DIV,
   parameter int LATCH_CYC = DEF_LATCH_CYC,
   parameter int HALF_CYC  = DEF_HALF_CYC,
   parameter int DAS_DELAY = DEF_DAS_DELAY,
   parameter int DAS_RATE  = DEF_DAS_RATE
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic       button_data,
   output logic       latch,
   output logic       pulse,
   output logic [7:0] buttons,
   output logic       frame_valid,
   output logic [6:0] cmd
);

   // Poll counter is sized for at least one second of clocks so any
   // sensible poll rate fits.
   localparam int POLL_W  = $clog2(max2(CLK_HZ, POLL_DIV) + 1);
   localparam int PHASE_W = $clog2(max2(LATCH_CYC, HALF_CYC) + 1);

   localparam logic [POLL_W-1:0]  POLL_LAST  = POLL_W'(POLL_DIV - 1);
   localparam logic [PHASE_W-1:0] LATCH_LAST = PHASE_W'(LATCH_CYC - 1);
   localparam logic [PHASE_W-1:0] HALF_LAST  = PHASE_W'(HALF_CYC - 1);

   state_e              state_q, state_d;
   logic [POLL_W-1:0]   poll_q, poll_d;
   logic [PHASE_W-1:0]  phase_q, phase_d;
   logic [2:0]          bit_q, bit_d;
   logic [6:0]          shift_q, shift_d;
   logic [7:0]          buttons_q, buttons_d;
   logic                latch_q, latch_d;
   logic                pulse_q, pulse_d;
   logic                frame_valid_q, frame_valid_d;
   logic [6:0]          cmd_q, cmd_d;

   logic                poll_tick;
   logic                frame_tick;
   logic                sample;
   logic [7:0]          new_buttons;
   logic                lr_both;
   logic [2:0]          rep_held, rep_inhibit, rep_fire;

   assign sample = ~button_data;

   // The eighth bit is taken straight from the pad on the last LOW cycle, so
   // the frame is complete on the same edge that enters DONE.
   assign new_buttons = {shift_q, sample};
   assign lr_both     = new_buttons[BTN_LEFT] & new_buttons[BTN_RIGHT];

   // ---------------------------------------------------------------- state reg
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         poll_q        <= '0;
         phase_q       <= '0;
         bit_q         <= '0;
         shift_q       <= '0;
         buttons_q     <= '0;
         latch_q       <= 1'b0;
         pulse_q       <= 1'b0;
         frame_valid_q <= 1'b0;
         cmd_q         <= '0;
      end else begin
         state_q       <= state_d;
         poll_q        <= poll_d;
         phase_q       <= phase_d;
         bit_q         <= bit_d;
         shift_q       <= shift_d;
         buttons_q     <= buttons_d;
         latch_q       <= latch_d;
         pulse_q       <= pulse_d;
         frame_valid_q <= frame_valid_d;
         cmd_q         <= cmd_d;
      end
   end

   // --------------------------------------------------------------- next state
   always_comb begin
      state_d    = state_q;
      phase_d    = phase_q;
      bit_d      = bit_q;
      shift_d    = shift_q;
      frame_tick = 1'b0;
      poll_tick  = (poll_q == POLL_LAST);
      poll_d     = poll_tick ? '0 : poll_q + POLL_W'(1);

      case (state_q)
         ST_IDLE: begin
            // A tick that arrives while busy or disabled is simply lost.
            if (poll_tick && enable) begin
               state_d = ST_LATCH;
               phase_d = '0;
               bit_d   = '0;
            end
         end
         ST_LATCH: begin
            if (phase_q == LATCH_LAST) begin
               state_d = ST_LOW;
               phase_d = '0;
            end else begin
               phase_d = phase_q + PHASE_W'(1);
            end
         end
         ST_LOW: begin
            if (phase_q == HALF_LAST) begin
               phase_d = '0;
               shift_d = {shift_q[5:0], sample};
               if (bit_q == 3'd7) begin
                  state_d    = ST_DONE;
                  frame_tick = 1'b1;
               end else begin
                  state_d = ST_HIGH;
               end
            end else begin
               phase_d = phase_q + PHASE_W'(1);
            end
         end
         ST_HIGH: begin
            if (phase_q == HALF_LAST) begin
               phase_d = '0;
               bit_d   = bit_q + 3'd1;
               state_d = ST_LOW;
            end else begin
               phase_d = phase_q + PHASE_W'(1);
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // -------------------------------------------------------- auto-repeat units
   // Index 2..0 = down, left, right, matching both the button and cmd bits.
   assign rep_held    = {new_buttons[BTN_DOWN], new_buttons[BTN_LEFT], new_buttons[BTN_RIGHT]};
   assign rep_inhibit = {1'b0, lr_both, lr_both};

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_rep
         autorepeat_unit #(
            .DAS_DELAY (DAS_DELAY),
            .DAS_RATE  (DAS_RATE)
         ) u_rep (
            .clk        (clk),
            .reset      (reset),
            .frame_tick (frame_tick),
            .held       (rep_held[gi]),
            .inhibit    (rep_inhibit[gi]),
            .fire       (rep_fire[gi])
         );
      end
   endgenerate

   // ------------------------------------------------------------------ outputs
   // Outputs are decoded from the next state so the registered strobes line
   // up exactly with the state they belong to.
   always_comb begin
      latch_d       = (state_d == ST_LATCH);
      pulse_d       = (state_d == ST_HIGH);
      frame_valid_d = frame_tick;
      buttons_d     = frame_tick ? new_buttons : buttons_q;
      cmd_d         = '0;
      if (frame_tick) begin
         // buttons_q still holds the previous frame here.
         cmd_d[CMD_ROT_CW]    = new_buttons[BTN_A]     & ~buttons_q[BTN_A];
         cmd_d[CMD_ROT_CCW]   = new_buttons[BTN_B]     & ~buttons_q[BTN_B];
         cmd_d[CMD_PAUSE]     = new_buttons[BTN_START] & ~buttons_q[BTN_START];
         cmd_d[CMD_HARD_DROP] = new_buttons[BTN_UP]    & ~buttons_q[BTN_UP];
         cmd_d[CMD_DOWN]      = rep_fire[2];
         cmd_d[CMD_LEFT]      = rep_fire[1];
         cmd_d[CMD_RIGHT]     = rep_fire[0];
      end
   end

   assign latch       = latch_q;
   assign pulse       = pulse_q;
   assign buttons     = buttons_q;
   assign frame_valid = frame_valid_q;
   assign cmd         = cmd_q;

endmodule
